// File: rtl/syscall_responder_pkg.sv
// Shared constants for the SYSCALL service unit: codes, widths, ASCII values, FSM encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package syscall_responder_pkg;

    localparam int W_CPU  = 32;
    localparam int W_BYTE = 8;

    // Syscall codes as seen in v0
    localparam int unsigned SYS_PRINT_HEX  = 1;
    localparam int unsigned SYS_EXIT       = 10;
    localparam int unsigned SYS_PRINT_CHAR = 11;

    // ASCII anchors for hex rendering and line termination
    localparam logic [W_BYTE-1:0] ASCII_ZERO = 8'h30;
    localparam logic [W_BYTE-1:0] ASCII_A_LC = 8'h61;
    localparam logic [W_BYTE-1:0] ASCII_NL   = 8'h0A;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HEX  = 3'd1,
        ST_CHAR = 3'd2,
        ST_NL   = 3'd3,
        ST_HALT = 3'd4
    } state_e;

endpackage

// File: rtl/syscall_responder_hex_to_ascii.sv
// Converts one 4-bit nibble to its lowercase ASCII hex digit.
// Latency: combinational.
// Backpressure: none; pure function of the input.
module syscall_responder_hex_to_ascii
    import syscall_responder_pkg::*;
(
    input  logic [3:0]        nibble_i,
    output logic [W_BYTE-1:0] ascii_o
);

    // Digits 0-9 map onto '0'..'9', 10-15 onto 'a'..'f'
    always_comb begin
        ascii_o = ASCII_ZERO;
        if (nibble_i < 4'd10) begin
            ascii_o = ASCII_ZERO + {4'b0000, nibble_i};
        end else begin
            ascii_o = ASCII_A_LC + {4'b0000, nibble_i} - 8'd10;
        end
    end

endmodule

// File: rtl/syscall_responder.sv
// SYSCALL service unit: renders PRINT_HEX / PRINT_CHAR as an ASCII byte stream, flags EXIT and bad codes.
// Latency: first byte valid the cycle after the accept edge; one byte per cycle when tx_ready is held high.
// Backpressure: tx_ready low holds tx_data/tx_valid; req_ready only in IDLE, no request queueing.
module syscall_responder
    import syscall_responder_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [W_CPU-1:0]  req_code,
    input  logic [W_CPU-1:0]  req_arg,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic [W_BYTE-1:0] tx_data,
    output logic              busy,
    output logic              halted,
    output logic              err
);

    state_e            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [W_CPU-1:0]  arg_q, arg_d;
    logic              halted_q, halted_d;
    logic              err_q, err_d;

    logic [3:0]        nibble;
    logic [W_BYTE-1:0] hex_ascii;

    // Current hex digit, most significant nibble first as cnt counts down from 7
    assign nibble = arg_q[{cnt_q, 2'b00} +: 4];

    syscall_responder_hex_to_ascii u_hex_to_ascii (
        .nibble_i (nibble),
        .ascii_o  (hex_ascii)
    );

    // State and datapath registers; reset aborts any transfer in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 3'd0;
            arg_q    <= '0;
            halted_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            arg_q    <= arg_d;
            halted_q <= halted_d;
            err_q    <= err_d;
        end
    end

    // Next-state: decode requests in IDLE, advance on each byte transfer elsewhere
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        arg_d    = arg_q;
        halted_d = halted_q;
        err_d    = err_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    if (req_code == W_CPU'(SYS_PRINT_HEX)) begin
                        arg_d   = req_arg;
                        cnt_d   = 3'd7;
                        state_d = ST_HEX;
                    end else if (req_code == W_CPU'(SYS_PRINT_CHAR)) begin
                        arg_d   = {{(W_CPU-W_BYTE){1'b0}}, req_arg[W_BYTE-1:0]};
                        state_d = ST_CHAR;
                    end else if (req_code == W_CPU'(SYS_EXIT)) begin
                        halted_d = 1'b1;
                        state_d  = ST_HALT;
                    end else begin
                        // Unsupported code is consumed immediately; only the sticky flag records it
                        err_d = 1'b1;
                    end
                end
            end
            ST_HEX: begin
                if (tx_ready) begin
                    cnt_d = cnt_q - 3'd1;
                    if (cnt_q == 3'd0) begin
                        state_d = ST_NL;
                    end
                end
            end
            ST_CHAR, ST_NL: begin
                if (tx_ready) begin
                    state_d = ST_IDLE;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs decoded from registered state only, so no input-to-output path exists
    always_comb begin
        tx_data = '0;
        case (state_q)
            ST_HEX:  tx_data = hex_ascii;
            ST_CHAR: tx_data = arg_q[W_BYTE-1:0];
            ST_NL:   tx_data = ASCII_NL;
            default: tx_data = '0;
        endcase
    end

    assign req_ready = (state_q == ST_IDLE);
    assign tx_valid  = (state_q == ST_HEX) || (state_q == ST_CHAR) || (state_q == ST_NL);
    assign busy      = tx_valid;
    assign halted    = halted_q;
    assign err       = err_q;

endmodule

// File: doc/syscall_responder.md
Name: syscall_responder

Overview:
- Target-side service unit for the single-cycle CPU's SYSCALL instruction. The CPU presents the code (v0) and argument (a0) over a valid/ready request channel.
- The block renders the result as ASCII bytes on a byte-wide valid/ready output stream for the console/UART path.
- Exit is signalled to the testbench/top via a sticky halted flag.
- This replaces the simulation-only $display/$finish handling with synthesizable hardware.

Parameters:
- W_CPU, 32, width of request code and argument words
- W_BYTE, 8, width of output character stream
- SYS_PRINT_HEX, 1, code: print argument as 8 lowercase hex digits plus newline
- SYS_EXIT, 10, code: halt
- SYS_PRINT_CHAR, 11, code: print argument[7:0] as one byte

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- req_valid  in  1  CPU presents a SYSCALL
- req_ready  out  1  block can accept a request
- req_code  in  W_CPU  syscall code (v0)
- req_arg  in  W_CPU  syscall argument (a0)
- tx_valid  out  1  tx_data holds a valid byte
- tx_ready  in  1  downstream accepts the byte
- tx_data  out  W_BYTE  ASCII byte
- busy  out  1  a request is being serviced (state != IDLE, HALT)
- halted  out  1  sticky; SYS_EXIT was accepted
- err  out  1  sticky; an unsupported code was accepted

Behaviour:
- Reset (rst=0, any time, asynchronous): state=IDLE, tx_valid=0, tx_data=0, busy=0, halted=0, err=0, digit counter=0, argument register=0. After release, req_ready=1.
- Reset mid-transmission aborts the transfer. No further bytes of that request are emitted.
- States: IDLE, HEX, CHAR, NL, HALT. All outputs are registered or decoded from registered state only. There is no combinational path from the tx_ready or req_* inputs to any output.
- req_ready = (state==IDLE). A request is accepted on a rising edge with req_valid & req_ready. req_code and req_arg are sampled only at acceptance.
- On acceptance, by req_code:
  - SYS_PRINT_HEX: latch arg, digit counter=7, go to HEX.
  - SYS_PRINT_CHAR: latch arg[7:0], go to CHAR.
  - SYS_EXIT: go to HALT, set halted. Nothing is emitted.
  - Any other code: set err, stay in IDLE. Nothing is emitted; the request is consumed in that one cycle.
- Latency: tx_valid rises on the first clock edge after acceptance, so the first byte is valid one cycle after the accept edge.
- Byte transfer occurs on a rising edge with tx_valid & tx_ready. While tx_valid=1 and tx_ready=0, tx_data is held stable and tx_valid stays 1. tx_valid never drops before its transfer.
- HEX: tx_data = ASCII of nibble arg[4*cnt+3 : 4*cnt], MSB nibble first. Nibbles 0-9 map to 0x30-0x39; 10-15 map to 0x61-0x66 (lowercase). On each transfer, cnt decrements. On the transfer where cnt==0, go to NL.
- NL: tx_data=0x0A. On transfer, go to IDLE.
- CHAR: tx_data=arg[7:0]. On transfer, go to IDLE.
- Leaving to IDLE: tx_valid goes to 0 on the same edge as the final transfer. req_ready is 1 from the following cycle.
- Throughput with tx_ready held at 1:
  - SYS_PRINT_HEX: 9 byte cycles; the next accept is possible 10 cycles after the previous accept.
  - SYS_PRINT_CHAR: next accept possible 2 cycles after the previous accept.
- HALT is terminal until reset: req_ready=0, tx_valid=0, halted=1. Requests are ignored and not consumed.
- err and halted are sticky, cleared only by reset.
- Request inputs are ignored while state != IDLE, even if req_valid=1 (no implicit queueing).

Decomposition:
- Shared package/defines header (alongside the existing opcode/funct defines): SYS_* codes, W_BYTE, ASCII constants (0x30, 0x61, 0x0A), and the state encoding (3-bit localparams).
- One natural sub-module, hex_to_ascii: combinational 4-bit nibble to 8-bit ASCII. Instantiated once, fed by a nibble mux indexed by cnt.

Test Plan:
- Reset then PRINT_HEX, arg=0x1234ABCD, tx_ready=1: bytes 0x31 0x32 0x33 0x34 0x61 0x62 0x63 0x64 0x0A on 9 consecutive cycles starting 1 cycle after accept. req_ready returns 1 after the 0x0A transfer.
- PRINT_HEX, arg=0x0000000F, tx_ready toggled 0/1 every cycle: same 9-byte sequence "0000000f\n" with tx_data stable across every stall cycle. No dropped or duplicated bytes.
- PRINT_CHAR, arg=0xFFFFFF41 -> single byte 0x41. Then code 7 -> err=1, req_ready stays 1, no tx_valid. Then PRINT_CHAR 0x42 still works -> 0x42.
- EXIT (code 10) -> halted=1 next cycle, req_ready=0. A subsequent PRINT_CHAR with req_valid held for 20 cycles -> no accept, tx_valid stays 0.
- PRINT_HEX 0xDEADBEEF with tx_ready=1, rst pulled low after the 3rd byte: tx_valid=0 immediately (asynchronous), all flags 0. After release req_ready=1 and no residual bytes appear.
- Back-to-back: req_valid held 1 with PRINT_CHAR 0x58 then PRINT_CHAR 0x59, tx_ready=1 -> accepts exactly 2 cycles apart. Output stream is 0x58, 0x59.
